// File: rtl/dqn_ctrl_pkg.sv
// Shared encodings and widths for the DQN control-unit timing interface.
// Phase numbering, FSM state codes and the phase-to-stage one-hot decode live here.
package dqn_ctrl_pkg;

  localparam int CTRL_W = 4;
  localparam int STEP_W = 4;
  localparam int EP_W   = 12;
  localparam int EPS_W  = 8;
  localparam int NSTAGE = 9;

  localparam logic [CTRL_W-1:0] PH_IDLE  = 4'd0;
  localparam logic [CTRL_W-1:0] PH_FIRST = 4'd1;
  localparam logic [CTRL_W-1:0] PH_LAST  = 4'd9;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_ERROR = 2'b10;

  // Phase k (1..9) maps to stage bit k-1; anything outside that range enables nothing.
  function automatic logic [NSTAGE-1:0] phase_onehot(input logic [CTRL_W-1:0] ph);
    logic [NSTAGE-1:0] oh;
    oh = 9'd0;
    if ((ph >= PH_FIRST) && (ph <= PH_LAST)) begin
      oh = 9'd1 << (ph - 4'd1);
    end else begin
      oh = 9'd0;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dqn_phase_sequencer_if.sv
// Control-unit timing inputs and decoded sequencer outputs as one bundle.
interface dqn_phase_sequencer_if;
  import dqn_ctrl_pkg::*;

  logic [CTRL_W-1:0] controller;
  logic [STEP_W-1:0] step;
  logic [EP_W-1:0]   episode;
  logic [NSTAGE-1:0] stage_en;
  logic              step_start;
  logic              episode_start;
  logic [STEP_W-1:0] ep_len;
  logic [EPS_W-1:0]  eps;
  logic              seq_err;
  logic [1:0]        fsm_state;

  modport master (
    output controller, step, episode,
    input  stage_en, step_start, episode_start, ep_len, eps, seq_err, fsm_state
  );

  modport slave (
    input  controller, step, episode,
    output stage_en, step_start, episode_start, ep_len, eps, seq_err, fsm_state
  );

endinterface

// File: rtl/dqn_phase_sequencer_eps_decay.sv
// Epsilon-greedy exploration register, decremented once per episode boundary
// and saturating at a floor value.
module eps_decay
  import dqn_ctrl_pkg::*;
#(
  parameter logic [EPS_W-1:0] EPS_INIT = 8'd255,
  parameter logic [EPS_W-1:0] EPS_DEC  = 8'd4,
  parameter logic [EPS_W-1:0] EPS_MIN  = 8'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_pulse,
  output logic [EPS_W-1:0] eps
);

  logic [EPS_W-1:0] eps_r;
  logic [EPS_W:0]   diff_s;
  logic [EPS_W-1:0] eps_nxt_s;

  // Nine-bit difference: the top bit flags a borrow, which also clamps to the floor.
  always_comb begin
    diff_s    = {1'b0, eps_r} - {1'b0, EPS_DEC};
    eps_nxt_s = EPS_MIN;
    if (diff_s[EPS_W] || (diff_s[EPS_W-1:0] < EPS_MIN)) begin
      eps_nxt_s = EPS_MIN;
    end else begin
      eps_nxt_s = diff_s[EPS_W-1:0];
    end
  end

  // Epsilon register: reload on reset, step down on each boundary pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      eps_r <= EPS_INIT;
    end else if (dec_pulse) begin
      eps_r <= eps_nxt_s;
    end else begin
      eps_r <= eps_r;
    end
  end

  assign eps = eps_r;

endmodule

// File: rtl/dqn_phase_sequencer.sv
// Follows the controller phase stream, emits registered one-hot stage enables,
// flags step/episode boundaries and traps illegal phase sequences.
module dqn_phase_sequencer
  import dqn_ctrl_pkg::*;
#(
  parameter int               N_PHASE  = 9,
  parameter logic [EPS_W-1:0] EPS_INIT = 8'd255,
  parameter logic [EPS_W-1:0] EPS_DEC  = 8'd4,
  parameter logic [EPS_W-1:0] EPS_MIN  = 8'd16
) (
  input  logic                  clk,
  input  logic                  rst,
  dqn_phase_sequencer_if.slave  bus
);

  localparam logic [CTRL_W-1:0] LAST_PH = CTRL_W'(N_PHASE);

  logic [1:0]        state_r;
  logic [CTRL_W-1:0] prev_ctrl_r;
  logic [STEP_W-1:0] prev_step_r;
  logic [EP_W-1:0]   prev_ep_r;
  logic [NSTAGE-1:0] stage_en_r;
  logic              step_start_r;
  logic              episode_start_r;
  logic [STEP_W-1:0] ep_len_r;
  logic              seq_err_r;
  logic [EPS_W-1:0]  eps_s;

  logic [1:0]        state_nxt_s;
  logic [CTRL_W-1:0] expected_s;
  logic              ep_diff_s;
  logic              legal_s;
  logic              ep_chg_s;
  logic              err_s;

  // Next-state decode: classify the sampled phase as legal, ignored or a protocol error.
  always_comb begin
    expected_s  = (prev_ctrl_r == LAST_PH) ? PH_FIRST : (prev_ctrl_r + 4'd1);
    ep_diff_s   = (bus.episode != prev_ep_r);
    state_nxt_s = state_r;
    legal_s     = 1'b0;
    ep_chg_s    = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Episode changes while idle are not boundaries; only phase 1 starts a run.
        if (bus.controller == PH_FIRST) begin
          legal_s     = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.controller == PH_IDLE) begin
          state_nxt_s = ST_IDLE;
        end else if ((bus.controller != expected_s) ||
                     (ep_diff_s && (bus.controller != PH_FIRST))) begin
          err_s       = 1'b1;
          state_nxt_s = ST_ERROR;
        end else begin
          legal_s     = 1'b1;
          ep_chg_s    = ep_diff_s;
          state_nxt_s = ST_RUN;
        end
      end
      ST_ERROR: begin
        state_nxt_s = ST_ERROR;
      end
      default: begin
        err_s       = 1'b1;
        state_nxt_s = ST_ERROR;
      end
    endcase
  end

  // State, input history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      prev_ctrl_r     <= 4'd0;
      prev_step_r     <= 4'd0;
      prev_ep_r       <= 12'd0;
      stage_en_r      <= 9'd0;
      step_start_r    <= 1'b0;
      episode_start_r <= 1'b0;
      ep_len_r        <= 4'd0;
      seq_err_r       <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      prev_ctrl_r     <= bus.controller;
      prev_step_r     <= bus.step;
      prev_ep_r       <= bus.episode;
      stage_en_r      <= legal_s ? phase_onehot(bus.controller) : 9'd0;
      step_start_r    <= legal_s && (bus.controller == PH_FIRST);
      episode_start_r <= ep_chg_s;
      ep_len_r        <= ep_chg_s ? prev_step_r : ep_len_r;
      seq_err_r       <= seq_err_r | err_s;
    end
  end

  eps_decay #(
    .EPS_INIT (EPS_INIT),
    .EPS_DEC  (EPS_DEC),
    .EPS_MIN  (EPS_MIN)
  ) u_eps_decay (
    .clk       (clk),
    .rst       (rst),
    .dec_pulse (ep_chg_s),
    .eps       (eps_s)
  );

  assign bus.stage_en      = stage_en_r;
  assign bus.step_start    = step_start_r;
  assign bus.episode_start = episode_start_r;
  assign bus.ep_len        = ep_len_r;
  assign bus.eps           = eps_s;
  assign bus.seq_err       = seq_err_r;
  assign bus.fsm_state     = state_r;

endmodule

// File: tb/tb_dqn_phase_sequencer.sv
// Scoreboard bench for dqn_phase_sequencer: each driven cycle queues its expected
// outputs; a monitor compares them one edge later, alongside directed spot checks.
module tb_dqn_phase_sequencer;
  import dqn_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  dqn_phase_sequencer_if bus();

  dqn_phase_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] stage_en;
    logic       step_start;
    logic       episode_start;
    logic [3:0] ep_len;
    logic [7:0] eps;
    logic       seq_err;
    logic [1:0] fsm_state;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ep_pulses = 0;

  // Reference state of the expected behaviour
  exp_t        m_out;
  logic [1:0]  m_state;
  logic [3:0]  m_prev_c;
  logic [3:0]  m_prev_s;
  logic [11:0] m_prev_e;

  task automatic model_step(input logic r, input logic [3:0] c, input logic [3:0] s, input logic [11:0] e);
    logic legal;
    logic chg;
    logic err;
    logic [3:0] expd;
    legal = 1'b0; chg = 1'b0; err = 1'b0;
    if (r) begin
      m_out = '{stage_en: 9'd0, step_start: 1'b0, episode_start: 1'b0, ep_len: 4'd0,
                eps: 8'd255, seq_err: 1'b0, fsm_state: 2'b00};
      m_state = 2'b00; m_prev_c = 4'd0; m_prev_s = 4'd0; m_prev_e = 12'd0;
    end else begin
      expd = (m_prev_c == 4'd9) ? 4'd1 : m_prev_c + 4'd1;
      if (m_state == 2'b00) begin
        if (c == 4'd1) begin legal = 1'b1; m_state = 2'b01; end
      end else if (m_state == 2'b01) begin
        if (c == 4'd0) m_state = 2'b00;
        else if (c != expd) err = 1'b1;
        else if ((e != m_prev_e) && (c != 4'd1)) err = 1'b1;
        else begin
          legal = 1'b1;
          chg = (e != m_prev_e);
        end
      end
      if (err) m_state = 2'b10;
      m_out.stage_en      = legal ? (9'd1 << (c - 4'd1)) : 9'd0;
      m_out.step_start    = legal && (c == 4'd1);
      m_out.episode_start = chg;
      if (chg) begin
        m_out.ep_len = m_prev_s;
        m_out.eps    = (m_out.eps >= 8'd20) ? (m_out.eps - 8'd4) : 8'd16;
      end
      m_out.seq_err   = m_out.seq_err | err;
      m_out.fsm_state = m_state;
      m_prev_c = c; m_prev_s = s; m_prev_e = e;
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] c, input logic [3:0] s, input logic [11:0] e);
    @(negedge clk);
    rst = r;
    bus.controller = c;
    bus.step = s;
    bus.episode = e;
    model_step(r, c, s, e);
    exp_q.push_back(m_out);
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Sample just after the edge that follows the vector just driven
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle with a pending expectation is compared against the outputs.
  initial begin : monitor
    exp_t exp_v;
    exp_t act_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {bus.stage_en, bus.step_start, bus.episode_start, bus.ep_len,
                 bus.eps, bus.seq_err, bus.fsm_state};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_out t=%0t: got se=%h ss=%b es=%b len=%0d eps=%0d err=%b st=%b, expected se=%h ss=%b es=%b len=%0d eps=%0d err=%b st=%b",
                   $time, act_v.stage_en, act_v.step_start, act_v.episode_start, act_v.ep_len,
                   act_v.eps, act_v.seq_err, act_v.fsm_state, exp_v.stage_en, exp_v.step_start,
                   exp_v.episode_start, exp_v.ep_len, exp_v.eps, exp_v.seq_err, exp_v.fsm_state);
        end
        if (act_v.episode_start === 1'b1) ep_pulses++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.controller = 4'd0;
    bus.step = 4'd0;
    bus.episode = 12'd0;

    // Reset held two cycles
    drive(1'b1, 4'd0, 4'd0, 12'd0);
    drive(1'b1, 4'd0, 4'd0, 12'd0);

    // Two full steps of phases 1..9
    for (int st = 1; st <= 2; st++)
      for (int p = 1; p <= 9; p++)
        drive(1'b0, 4'(p), 4'(st), 12'd0);
    settle();
    check_val("t1_stage_last", int'(bus.stage_en), 256);
    check_val("t1_state_run", int'(bus.fsm_state), 1);

    // Step 5 in episode 0, then 64 episode boundaries
    for (int p = 1; p <= 9; p++) drive(1'b0, 4'(p), 4'd5, 12'd0);
    for (int e = 1; e <= 64; e++) begin
      for (int p = 1; p <= 9; p++) begin
        drive(1'b0, 4'(p), 4'(e), 12'(e));
        if (p == 1) begin
          if (e == 1) begin
            settle();
            check_val("t2_ep_start", int'(bus.episode_start), 1);
            check_val("t2_ep_len", int'(bus.ep_len), 5);
            check_val("t2_eps", int'(bus.eps), 251);
          end else if (e == 59) begin
            settle();
            check_val("t3_eps_59", int'(bus.eps), 19);
          end else if (e == 60) begin
            settle();
            check_val("t3_eps_60", int'(bus.eps), 16);
          end
        end
      end
    end
    settle();
    check_val("t3_ep_pulses", ep_pulses, 64);
    check_val("t3_eps_floor", int'(bus.eps), 16);

    // Skipped phase 4 traps into ERROR; reset recovers
    drive(1'b1, 4'd0, 4'd0, 12'd0);
    drive(1'b0, 4'd1, 4'd0, 12'd0);
    drive(1'b0, 4'd2, 4'd0, 12'd0);
    drive(1'b0, 4'd3, 4'd0, 12'd0);
    drive(1'b0, 4'd5, 4'd0, 12'd0);
    settle();
    check_val("t4_state_err", int'(bus.fsm_state), 2);
    check_val("t4_seq_err", int'(bus.seq_err), 1);
    drive(1'b0, 4'd6, 4'd0, 12'd0);
    drive(1'b0, 4'd7, 4'd0, 12'd0);
    settle();
    check_val("t4_stage_zero", int'(bus.stage_en), 0);
    drive(1'b1, 4'd0, 4'd0, 12'd0);
    settle();
    check_val("t4_rst_state", int'(bus.fsm_state), 0);
    check_val("t4_rst_eps", int'(bus.eps), 255);

    // Upstream reset at phase 4; idle ignores junk phases and episode changes
    for (int p = 1; p <= 4; p++) drive(1'b0, 4'(p), 4'd2, 12'd0);
    drive(1'b0, 4'd0, 4'd2, 12'd0);
    settle();
    check_val("t5_idle", int'(bus.fsm_state), 0);
    check_val("t5_no_err", int'(bus.seq_err), 0);
    drive(1'b0, 4'd3, 4'd2, 12'd2);
    drive(1'b0, 4'd0, 4'd2, 12'd5);
    drive(1'b0, 4'd1, 4'd3, 12'd7);
    settle();
    check_val("t5_stage_1", int'(bus.stage_en), 1);
    check_val("t5_run", int'(bus.fsm_state), 1);
    check_val("t5_no_ep_start", int'(bus.episode_start), 0);

    // One boundary, then an episode change at phase 6
    for (int p = 2; p <= 9; p++) drive(1'b0, 4'(p), 4'd3, 12'd7);
    for (int p = 1; p <= 5; p++) drive(1'b0, 4'(p), 4'd4, 12'd8);
    drive(1'b0, 4'd6, 4'd4, 12'd9);
    settle();
    check_val("t6_state_err", int'(bus.fsm_state), 2);
    check_val("t6_ep_len_hold", int'(bus.ep_len), 3);
    check_val("t6_eps_hold", int'(bus.eps), 251);
    drive(1'b0, 4'd7, 4'd4, 12'd9);
    drive(1'b0, 4'd1, 4'd5, 12'd10);

    settle();
    check_val("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dqn_phase_sequencer.md
Name: dqn_phase_sequencer

Overview:
- Consumer of the control-unit timing outputs: `controller` phase 1..9, `step` and `episode`.
- Decodes the phase into registered one-hot stage enables for the DQN datapath.
- Checks that the phase sequence is legal, marks step and episode boundaries, and records the length of the last episode.
- Keeps the epsilon-greedy exploration value, decayed once per episode.

Parameters:
- N_PHASE, 9, number of controller phases per step (legal values 1..N_PHASE).
- EPS_INIT, 8'd255, epsilon value after reset.
- EPS_DEC, 8'd4, amount subtracted from epsilon at each episode boundary.
- EPS_MIN, 8'd16, lower limit for epsilon.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- controller  in  4  phase from the control unit; 0 = idle/reset, 1..9 = active phase.
- step  in  4  step index from the control unit.
- episode  in  12  episode index from the control unit.
- stage_en  out  9  one-hot stage enable; bit k-1 is active for phase k.
- step_start  out  1  one-cycle pulse at the start of each step.
- episode_start  out  1  one-cycle pulse at an episode change.
- ep_len  out  4  final step value of the last completed episode.
- eps  out  8  current epsilon.
- seq_err  out  1  sticky protocol-error flag.
- fsm_state  out  2  00 IDLE, 01 RUN, 10 ERROR.

Behaviour:
- All outputs are registered. Values after rst: stage_en=0, step_start=0, episode_start=0, ep_len=0, eps=EPS_INIT, seq_err=0, fsm_state=IDLE.
- Internal registers prev_ctrl, prev_step and prev_ep reset to 0; they sample the inputs every cycle outside reset.
- FSM, IDLE:
  - controller==1 → go to RUN and act on this phase.
  - controller==0 → stay in IDLE.
  - any other value → stay in IDLE, no outputs, no error.
- FSM, RUN:
  - expected = (prev_ctrl==N_PHASE) ? 1 : prev_ctrl+1.
  - controller==expected → stay in RUN.
  - controller==0 → go to IDLE, no error (upstream was reset).
  - any other value → go to ERROR and set seq_err=1.
- FSM, ERROR: absorbing. Leaves only on rst. While in ERROR, stage_en, step_start and episode_start are held at 0. eps and ep_len are frozen.
- Stage enables:
  - When a legal phase k is sampled at edge n (in IDLE→RUN or RUN), stage_en equals 1<<(k-1) for the cycle after edge n. Latency 1.
  - Otherwise stage_en=0.
  - In a legal sequence, never more than one bit is set.
- step_start: asserted for one cycle with the same latency as stage_en, whenever a legal phase 1 is sampled.
- Episode boundary:
  - episode != prev_ep while in RUN, together with a legal phase 1 → episode_start pulses with latency 1.
  - On that pulse: ep_len <= prev_step, and eps <= max(eps-EPS_DEC, EPS_MIN). Subtraction is done in 9 bits so it cannot underflow.
  - An episode change in any phase other than 1 is a protocol error and takes the FSM to ERROR.
  - Any change of episode while in IDLE is ignored.
- Wrap-around:
  - Phase 9→1 is the legal wrap.
  - A step wrap (15→1) or an episode wrap (4095→0) is treated as an ordinary change.
  - Once eps reaches EPS_MIN it stays there.
- Simultaneous events: rst wins over everything. An episode change and a step start in the same cycle raise both pulses.
- rst mid-step: all state clears on the next edge, and the block waits in IDLE for phase 1.

Decomposition:
- Shared package `dqn_ctrl_pkg` holds:
  - the phase encodings (PH_IDLE=0, PH_FIRST=1, PH_LAST=9);
  - the FSM state encoding;
  - the epsilon width (8) and the counter widths (4 and 12).
- One natural sub-module, `eps_decay`, containing the epsilon register with its saturating decrement; its inputs are dec_pulse and rst.

Test Plan:
1. Hold rst for 2 cycles, then drive controller 1..9 repeatedly → stage_en goes 001h,002h,…,100h one cycle late; step_start fires once per step; fsm_state=01.
2. Drive phases 1..9, then 1, with episode changing 0→1 at the second phase 1 and step=5 beforehand → episode_start pulses once, ep_len=5, eps=251.
3. Drive 64 legal episode boundaries → eps reaches 16 after 60 decrements and stays at 16; episode_start count equals 64.
4. Drive phases 1,2,3,5 → seq_err=1 and fsm_state=10 one cycle after phase 5; stage_en=0 from then on; pulse rst → all reset values return.
5. In RUN at phase 4, drive controller=0 → fsm_state=00, seq_err=0; later drive phase 1 → back to RUN with stage_en=001h.
6. Drive an episode change at phase 6 → ERROR; ep_len and eps hold their previous values.
